// File: rtl/handshake_elastic_fifo.sv
// ---------------------------------------------------------------------------
// handshake_elastic_fifo
//
// Elastic FIFO for the dataflow handshake fabric. Buffers up to NUM_SLOTS
// tokens in order between a valid/ready producer and a valid/ready consumer.
// ins_ready is derived from registered occupancy only, so there is no
// combinational path from outs_ready back to ins_ready.
//
// Parameters
//   DATA_WIDTH  token payload width in bits
//   NUM_SLOTS   storage depth in tokens (2..64, any integer)
//
// Ports
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-low reset
//   ins         input token payload
//   ins_valid   producer offers a token
//   ins_ready   FIFO accepts a token this cycle
//   outs        output token payload (zero when outs_valid is low)
//   outs_valid  FIFO offers a token
//   outs_ready  consumer accepts the token
//
// Optional feature
//   HANDSHAKE_ELASTIC_FIFO_BYPASS_EN: when the FIFO is empty the input
//   token is presented combinationally on the output; if it is consumed in
//   the same cycle it is never written to storage.
// ---------------------------------------------------------------------------
module handshake_elastic_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLOTS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int CNT_W = $clog2(NUM_SLOTS + 1);

    logic [DATA_WIDTH-1:0] r_mem [NUM_SLOTS];
    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_pass;
    logic w_wr;
    logic w_rd;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] f_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_SLOTS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        w_full  = (r_count == CNT_W'(NUM_SLOTS));
        w_empty = (r_count == '0);
    end

    // Registered state only: a pop while full does not open the input.
    always_comb begin
        ins_ready = rst & ~w_full;
    end

`ifdef HANDSHAKE_ELASTIC_FIFO_BYPASS_EN
    // Bypass is gated by rst so the output stays quiet during reset.
    always_comb begin
        w_pass = w_empty & rst & ins_valid & outs_ready;
        if (w_empty) begin
            outs_valid = rst & ins_valid;
            outs       = (rst & ins_valid) ? ins : '0;
        end else begin
            outs_valid = 1'b1;
            outs       = r_mem[r_head];
        end
    end
`else
    always_comb begin
        w_pass     = 1'b0;
        outs_valid = ~w_empty;
        outs       = w_empty ? '0 : r_mem[r_head];
    end
`endif

    // A passed-through token counts as both a push and a pop on the channel
    // but touches neither storage nor pointers.
    always_comb begin
        w_push = ins_valid & ins_ready;
        w_pop  = outs_valid & outs_ready;
        w_wr   = w_push & ~w_pass;
        w_rd   = w_pop & ~w_pass;
    end

    // Storage is not reset; w_wr is already qualified by rst via ins_ready.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_tail] <= ins;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_wr) begin
                r_tail <= f_next(r_tail);
            end
            if (w_rd) begin
                r_head <= f_next(r_head);
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
module tb_handshake_elastic_fifo;

`ifdef HANDSHAKE_ELASTIC_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // DUT 0: NUM_SLOTS=4, DUT 1: NUM_SLOTS=3
    logic        r0, v0, or0, ir0, ov0;
    logic [31:0] d0, o0;
    logic        r1, v1, or1, ir1, ov1;
    logic [31:0] d1, o1;

    handshake_elastic_fifo #(.DATA_WIDTH(32), .NUM_SLOTS(4)) u_fifo4 (
        .clk(clk), .rst(r0), .ins(d0), .ins_valid(v0), .ins_ready(ir0),
        .outs(o0), .outs_valid(ov0), .outs_ready(or0)
    );

    handshake_elastic_fifo #(.DATA_WIDTH(32), .NUM_SLOTS(3)) u_fifo3 (
        .clk(clk), .rst(r1), .ins(d1), .ins_valid(v1), .ins_ready(ir1),
        .outs(o1), .outs_valid(ov1), .outs_ready(or1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one in-order queue per DUT.
    logic [31:0] q0[$];
    logic [31:0] q1[$];

    typedef struct {
        logic        r;
        logic        v;
        logic [31:0] data;
        logic        ordy;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_out;
    } vec_t;

    vec_t tbl[20];

    logic        s_ov, s_rdy;
    logic [31:0] s_out;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle on DUT d. mode 0: no check, 1: check against model,
    // 2: check against the supplied expected values. Model updates always.
    task automatic step(input int d, input logic r, input logic v,
                        input logic [31:0] data, input logic ordy,
                        input int mode, input logic erdy, input logic eov,
                        input logic [31:0] eout,
                        output logic ov_o, output logic [31:0] out_o,
                        output logic rdy_o);
        logic [31:0] q[$];
        int          cap;
        logic        m_rdy, m_ov, push, pop;
        logic [31:0] m_out;
        if (d == 0) begin q = q0; cap = 4; end
        else        begin q = q1; cap = 3; end
        @(negedge clk);
        if (d == 0) begin r0 = r; v0 = v; d0 = data; or0 = ordy; end
        else        begin r1 = r; v1 = v; d1 = data; or1 = ordy; end
        #1;
        if (d == 0) begin rdy_o = ir0; ov_o = ov0; out_o = o0; end
        else        begin rdy_o = ir1; ov_o = ov1; out_o = o1; end
        m_rdy = r && (q.size() < cap);
        if (q.size() > 0)        begin m_ov = 1'b1; m_out = q[0]; end
        else if (BYP && r && v)  begin m_ov = 1'b1; m_out = data; end
        else                     begin m_ov = 1'b0; m_out = '0;   end
        if (mode == 1) begin
            chk("model_ins_ready",  {31'd0, rdy_o}, {31'd0, m_rdy});
            chk("model_outs_valid", {31'd0, ov_o},  {31'd0, m_ov});
            chk("model_outs",       out_o,          m_out);
        end else if (mode == 2) begin
            chk("tbl_ins_ready",  {31'd0, rdy_o}, {31'd0, erdy});
            chk("tbl_outs_valid", {31'd0, ov_o},  {31'd0, eov});
            chk("tbl_outs",       out_o,          eout);
        end
        @(posedge clk);
        if (!r) begin
            q.delete();
        end else begin
            push = v && m_rdy;
            pop  = m_ov && ordy;
            if (!(BYP && q.size() == 0 && push && pop)) begin
                if (pop)  void'(q.pop_front());
                if (push) q.push_back(data);
            end
        end
        if (d == 0) q0 = q; else q1 = q;
    endtask

    function automatic vec_t mk(logic r, logic v, logic [31:0] data, logic ordy,
                                logic e_rdy, logic e_ov, logic [31:0] e_out);
        vec_t t;
        t.r = r; t.v = v; t.data = data; t.ordy = ordy;
        t.e_rdy = e_rdy; t.e_ov = e_ov; t.e_out = e_out;
        return t;
    endfunction

    initial begin
        logic [31:0] rx[$];
        int          sent;
        int          bubbles;
        logic [31:0] want;

        r0 = 0; v0 = 0; d0 = '0; or0 = 0;
        r1 = 0; v1 = 0; d1 = '0; or1 = 0;

        // Reset, fill/drain, full simultaneous event on NUM_SLOTS=4.
        tbl[0]  = mk(0, 1, 32'h55, 0, 0, 0, 32'h0);
        tbl[1]  = mk(0, 1, 32'h55, 0, 0, 0, 32'h0);
        tbl[2]  = mk(0, 1, 32'h55, 0, 0, 0, 32'h0);
        tbl[3]  = mk(1, 1, 32'hA1, 0, 1, BYP, BYP ? 32'hA1 : 32'h0);
        tbl[4]  = mk(1, 1, 32'hA2, 0, 1, 1, 32'hA1);
        tbl[5]  = mk(1, 1, 32'hA3, 0, 1, 1, 32'hA1);
        tbl[6]  = mk(1, 1, 32'hA4, 0, 1, 1, 32'hA1);
        tbl[7]  = mk(1, 1, 32'hA5, 0, 0, 1, 32'hA1);
        tbl[8]  = mk(1, 0, 32'h0,  1, 0, 1, 32'hA1);
        tbl[9]  = mk(1, 0, 32'h0,  1, 1, 1, 32'hA2);
        tbl[10] = mk(1, 0, 32'h0,  1, 1, 1, 32'hA3);
        tbl[11] = mk(1, 0, 32'h0,  1, 1, 1, 32'hA4);
        tbl[12] = mk(1, 0, 32'h0,  1, 1, 0, 32'h0);
        tbl[13] = mk(1, 1, 32'hB1, 0, 1, BYP, BYP ? 32'hB1 : 32'h0);
        tbl[14] = mk(1, 1, 32'hB2, 0, 1, 1, 32'hB1);
        tbl[15] = mk(1, 1, 32'hB3, 0, 1, 1, 32'hB1);
        tbl[16] = mk(1, 1, 32'hB4, 0, 1, 1, 32'hB1);
        tbl[17] = mk(1, 1, 32'hB5, 1, 0, 1, 32'hB1);
        tbl[18] = mk(1, 1, 32'hB5, 0, 1, 1, 32'hB2);
        tbl[19] = mk(1, 1, 32'hB6, 0, 0, 1, 32'hB2);

        // Initial reset edge establishes a known state before any checks.
        step(0, 0, 0, '0, 0, 0, 0, 0, '0, s_ov, s_out, s_rdy);
        for (int unsigned i = 0; i < 20; i++)
            step(0, tbl[i].r, tbl[i].v, tbl[i].data, tbl[i].ordy, 2,
                 tbl[i].e_rdy, tbl[i].e_ov, tbl[i].e_out, s_ov, s_out, s_rdy);

        // Drain.
        for (int unsigned i = 0; i < 8; i++)
            step(0, 1, 0, '0, 1, 1, 0, 0, '0, s_ov, s_out, s_rdy);
        chk("drained_empty", {31'd0, s_ov}, 32'd0);

        // Streaming from empty: one token per cycle, no bubbles after the first.
        bubbles = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            step(0, 1, 1, 32'h10 + i, 1, 1, 0, 0, '0, s_ov, s_out, s_rdy);
            if (BYP || i > 0) begin
                want = BYP ? 32'h10 + i : 32'h10 + i - 1;
                if (!s_ov || s_out !== want) bubbles++;
            end
        end
        chk("stream_no_bubbles", bubbles, 32'd0);
        for (int unsigned i = 0; i < 6; i++)
            step(0, 1, 0, '0, 1, 1, 0, 0, '0, s_ov, s_out, s_rdy);

        // Mid-operation reset with 2 tokens buffered.
        step(0, 1, 1, 32'hE1, 0, 1, 0, 0, '0, s_ov, s_out, s_rdy);
        step(0, 1, 1, 32'hE2, 0, 1, 0, 0, '0, s_ov, s_out, s_rdy);
        step(0, 0, 1, 32'hE3, 1, 1, 0, 0, '0, s_ov, s_out, s_rdy);
        step(0, 1, 0, '0, 0, 1, 0, 0, '0, s_ov, s_out, s_rdy);
        chk("post_reset_valid", {31'd0, s_ov}, 32'd0);
        chk("post_reset_ready", {31'd0, s_rdy}, 32'd1);
        step(0, 1, 1, 32'hDEAD_BEEF, 0, 1, 0, 0, '0, s_ov, s_out, s_rdy);
        step(0, 1, 0, '0, 1, 1, 0, 0, '0, s_ov, s_out, s_rdy);
        chk("post_reset_first_out", s_out, 32'hDEAD_BEEF);
        chk("post_reset_first_valid", {31'd0, s_ov}, 32'd1);

        // Random traffic on NUM_SLOTS=4 with occasional resets.
        for (int unsigned i = 0; i < 300; i++)
            step(0, ($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
                 $urandom, 1'($urandom_range(0, 1)), 1, 0, 0, '0, s_ov, s_out, s_rdy);

        // Wrap on NUM_SLOTS=3: C0..C9 with random stalls on both sides.
        step(1, 0, 0, '0, 0, 0, 0, 0, '0, s_ov, s_out, s_rdy);
        sent = 0;
        for (int unsigned i = 0; i < 300 && rx.size() < 10; i++) begin
            logic v, o;
            v = (sent < 10) && ($urandom_range(0, 2) != 0);
            o = ($urandom_range(0, 2) != 0);
            step(1, 1, v, 32'hC0 + sent, o, 1, 0, 0, '0, s_ov, s_out, s_rdy);
            if (v && s_rdy) sent++;
            if (s_ov && o) rx.push_back(s_out);
        end
        chk("wrap_count", rx.size(), 32'd10);
        for (int unsigned i = 0; i < 10; i++) begin
            if (i < rx.size()) chk("wrap_order", rx[i], 32'hC0 + i);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/handshake_elastic_fifo.md
# handshake_elastic_fifo

Parameterised elastic FIFO for the dataflow handshake fabric. Sits directly downstream of constant and other token-producing units and absorbs back-pressure between them and their consumers. It buffers up to NUM_SLOTS data tokens in order, cuts the combinational ready path, and presents the standard valid/ready channel on both sides.

## Interface

**Parameters**
- DATA_WIDTH, 32, token payload width in bits.
- NUM_SLOTS, 4, storage depth in tokens; legal range 2..64, power of two not required.

**Ports**
- clk  in  1  sole clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous and active-low (asserted when 0, sampled on clk rising edge).
- ins  in  DATA_WIDTH  input token payload.
- ins_valid  in  1  producer offers a token.
- ins_ready  out  1  FIFO accepts a token this cycle.
- outs  out  DATA_WIDTH  output token payload.
- outs_valid  out  1  FIFO offers a token.
- outs_ready  in  1  consumer accepts the token.

## Operation

- **State**
  - Storage array mem[NUM_SLOTS] (not reset).
  - head and tail pointers, each clog2(NUM_SLOTS) bits wide.
  - count, 0..NUM_SLOTS, clog2(NUM_SLOTS+1) bits wide.
- **Transfers**
  - Push when ins_valid & ins_ready: mem[tail] <= ins, tail advances.
  - Pop when outs_valid & outs_ready: head advances.
  - A pointer at NUM_SLOTS-1 wraps to 0; the wrap is explicit, not modulo-2^n.
- **Flags**
  - ins_ready = rst & (count != NUM_SLOTS).
  - ins_ready is a function of registered state only and never depends on outs_ready.
  - outs_valid = (count != 0); outs = mem[head] when outs_valid, else all zeros.
- **Count update**
  - count increments on push only, decrements on pop only, and is unchanged on simultaneous push+pop.
- **Boundary conditions**
  - Full: ins_ready=0. A pop in the same cycle does not enable a push; ins_ready rises the cycle after.
  - Empty: outs_valid=0 (without bypass). A push does not appear at the output until the next cycle.
  - Single entry with simultaneous push+pop: the old token leaves, the new token is stored, count stays 1.
  - Reset asserted mid-operation: all buffered tokens are discarded, and any handshake in that cycle is ignored.
- **Reset values** (rst low at an edge): head=0, tail=0, count=0, outs_valid=0, outs=0, ins_ready=0 while rst is low.

## Timing

- Latency: a token accepted at edge N is offered on outs from cycle N+1. Bypass case: see Configuration.
- Throughput: one token per cycle sustained when neither side stalls and count is between 1 and NUM_SLOTS-1.
- Stall stability: while outs_valid=1 and outs_ready=0, outs and outs_valid hold constant until the pop.
- First cycle after rst returns high: ins_ready=1, outs_valid=0.
- No combinational path from outs_ready to ins_ready.
- No path from ins_valid/ins to outs/outs_valid, except under the bypass macro.

## Configuration

- Macro: HANDSHAKE_ELASTIC_FIFO_BYPASS_EN.
- **Defined**
  - When count==0: outs_valid = ins_valid and outs = ins, combinationally.
  - If outs_ready=1 in that cycle, the token passes straight through with zero latency: no write, pointers and count unchanged.
  - If outs_ready=0, the token is written normally and offered from the next cycle. It must equal the value shown in the bypass cycle.
  - Adds one combinational valid/data path; the ready path is still cut.
- **Undefined**
  - No bypass; minimum latency is 1 cycle as specified above.

## Test plan

- **Reset:** hold rst=0 for 3 cycles with ins_valid=1 -> ins_ready=0, outs_valid=0, outs=0. After release: ins_ready=1, count=0.
- **Fill/drain, NUM_SLOTS=4:** push 32'h0000_00A1..A4 with outs_ready=0 -> ins_ready=0 after the 4th push. Then set outs_ready=1 -> A1, A2, A3, A4 out in order, outs_valid=0 afterwards.
- **Streaming:** ins_valid=1 and outs_ready=1 every cycle with an incrementing payload from 32'h10 -> each value appears one cycle later (zero cycles with bypass defined), with no bubbles after the first.
- **Full simultaneous event:** FIFO full, outs_ready=1, ins_valid=1 -> pop occurs, no push that cycle, ins_ready=1 next cycle, count=3.
- **Wrap, NUM_SLOTS=3:** push/pop 10 tokens 32'hC0..C9 with random stalls -> exact order preserved across pointer wrap, and count never exceeds 3.
- **Mid-operation reset:** 2 tokens buffered, rst=0 for one cycle -> outs_valid=0 next cycle, and the next pushed token 32'hDEAD_BEEF is the first output.
